// File: rtl/sipo_rx.sv
// Serial-in / parallel-out receiver: assembles DATA_WIDTH serial bits into a word,
// offers it through a valid/ready holding register, and flags words lost to overrun.
`timescale 1ns/1ps

module sipo_rx #(
  parameter int DATA_WIDTH = 4,
  parameter int CLOCK_EDGE = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_in,
  input  logic                  d_valid_in,
  output logic [DATA_WIDTH-1:0] q_out,
  output logic                  q_valid_out,
  input  logic                  q_ready_in,
  input  logic                  out_enable_in,
  output logic                  overrun_out
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                  act_clk_s;
  logic [DATA_WIDTH-1:0] sreg_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [DATA_WIDTH-1:0] hold_r;
  logic                  full_r;
  logic                  ovr_r;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  complete_s;
  logic                  xfer_s;

  // Falling-edge builds run the same state machine on an inverted clock.
  generate
    if (CLOCK_EDGE != 0) begin : g_rise
      assign act_clk_s = clk;
    end else begin : g_fall
      assign act_clk_s = ~clk;
    end
  endgenerate

  // Next shift value, word completion and handshake transfer decode.
  always_comb begin
    word_s     = '0;
    complete_s = 1'b0;
    xfer_s     = 1'b0;
    if (LSB_FIRST != 0) begin
      word_s = {d_in, sreg_r[DATA_WIDTH-1:1]};
    end else begin
      word_s = {sreg_r[DATA_WIDTH-2:0], d_in};
    end
    complete_s = d_valid_in && (cnt_r == LAST_CNT);
    xfer_s     = full_r && q_ready_in && out_enable_in;
  end

  // Shift register, bit counter, holding register, full and sticky overrun flags.
  always_ff @(posedge act_clk_s or negedge rst) begin
    if (!rst) begin
      sreg_r <= '0;
      cnt_r  <= '0;
      hold_r <= '0;
      full_r <= 1'b0;
      ovr_r  <= 1'b0;
    end else begin
      if (d_valid_in) begin
        sreg_r <= word_s;
        cnt_r  <= complete_s ? '0 : (cnt_r + CNT_ONE);
      end
      // A completed word is accepted only if the holding register is free or draining now.
      if (complete_s) begin
        if (!full_r || xfer_s) begin
          hold_r <= word_s;
          full_r <= 1'b1;
        end else begin
          ovr_r <= 1'b1;
        end
      end else if (xfer_s) begin
        full_r <= 1'b0;
      end
    end
  end

  assign q_out       = out_enable_in ? hold_r : '0;
  assign q_valid_out = out_enable_in & full_r;
  assign overrun_out = ovr_r;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed self-checking bench for sipo_rx (DATA_WIDTH=4, rising edge, LSB first).
`timescale 1ns/1ps

module tb_sipo_rx;

  logic       clk;
  logic       rst;
  logic       d_in;
  logic       d_valid_in;
  logic [3:0] q_out;
  logic       q_valid_out;
  logic       q_ready_in;
  logic       out_enable_in;
  logic       overrun_out;

  int n_checks;
  int n_fail;

  sipo_rx #(
    .DATA_WIDTH(4),
    .CLOCK_EDGE(1),
    .LSB_FIRST (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .d_in         (d_in),
    .d_valid_in   (d_valid_in),
    .q_out        (q_out),
    .q_valid_out  (q_valid_out),
    .q_ready_in   (q_ready_in),
    .out_enable_in(out_enable_in),
    .overrun_out  (overrun_out)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    d_in       = b;
    d_valid_in = 1'b1;
    tick();
    d_valid_in = 1'b0;
    d_in       = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) send(w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  // Directed scenarios, each with hand-derived expectations.
  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b0;
    d_in          = 1'b0;
    d_valid_in    = 1'b0;
    q_ready_in    = 1'b1;
    out_enable_in = 1'b1;
    #3;
    check_eq("rst_q", 32'(q_out), 32'h0);
    check_eq("rst_valid", 32'(q_valid_out), 32'h0);
    check_eq("rst_ovr", 32'(overrun_out), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Single word 1,0,0,1 with consumer ready: valid lasts exactly one cycle.
    send(1'b1); send(1'b0); send(1'b0);
    check_eq("w1_partial_valid", 32'(q_valid_out), 32'h0);
    send(1'b1);
    check_eq("w1_q", 32'(q_out), 32'h9);
    check_eq("w1_valid", 32'(q_valid_out), 32'h1);
    tick();
    check_eq("w1_valid_drop", 32'(q_valid_out), 32'h0);
    check_eq("w1_ovr", 32'(overrun_out), 32'h0);

    // Consumer stalled: second word is lost and overrun sticks.
    do_reset();
    q_ready_in = 1'b0;
    send_word(4'b1001);
    check_eq("ov_q1", 32'(q_out), 32'h9);
    check_eq("ov_valid1", 32'(q_valid_out), 32'h1);
    send(1'b0); send(1'b1); send(1'b1);
    check_eq("ov_pre_ovr", 32'(overrun_out), 32'h0);
    check_eq("ov_hold_stable", 32'(q_out), 32'h9);
    send(1'b0);
    check_eq("ov_ovr_set", 32'(overrun_out), 32'h1);
    check_eq("ov_q_kept", 32'(q_out), 32'h9);
    check_eq("ov_valid_kept", 32'(q_valid_out), 32'h1);
    tick(); tick();
    check_eq("ov_ovr_sticky", 32'(overrun_out), 32'h1);
    q_ready_in = 1'b1;
    tick();
    check_eq("ov_drain_valid", 32'(q_valid_out), 32'h0);
    check_eq("ov_sticky_after_xfer", 32'(overrun_out), 32'h1);

    // Asynchronous reset mid-word with a word held: everything clears without a clock.
    q_ready_in = 1'b0;
    send_word(4'b1001);
    send(1'b1); send(1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_q", 32'(q_out), 32'h0);
    check_eq("arst_valid", 32'(q_valid_out), 32'h0);
    check_eq("arst_ovr", 32'(overrun_out), 32'h0);
    #1;
    rst = 1'b1;
    q_ready_in = 1'b1;
    send(1'b0); send(1'b1); send(1'b1);
    check_eq("arst_no_residue", 32'(q_valid_out), 32'h0);
    send(1'b0);
    check_eq("arst_q_new", 32'(q_out), 32'h6);
    check_eq("arst_valid_new", 32'(q_valid_out), 32'h1);

    // Gaps in d_valid_in: bits 1,1,<gap x3>,0,1 form one word 4'b1011.
    do_reset();
    send(1'b1); send(1'b1);
    d_in = 1'b1;
    tick(); tick(); tick();
    check_eq("gap_no_valid", 32'(q_valid_out), 32'h0);
    send(1'b0);
    check_eq("gap_no_early", 32'(q_valid_out), 32'h0);
    send(1'b1);
    check_eq("gap_q", 32'(q_out), 32'hB);
    check_eq("gap_valid", 32'(q_valid_out), 32'h1);

    // Transfer on the completing edge: valid never drops, no overrun.
    do_reset();
    q_ready_in = 1'b0;
    send_word(4'b1001);
    send(1'b0); send(1'b1); send(1'b1);
    check_eq("b2b_q1", 32'(q_out), 32'h9);
    check_eq("b2b_valid1", 32'(q_valid_out), 32'h1);
    q_ready_in = 1'b1;
    send(1'b0);
    check_eq("b2b_q2", 32'(q_out), 32'h6);
    check_eq("b2b_valid2", 32'(q_valid_out), 32'h1);
    check_eq("b2b_ovr", 32'(overrun_out), 32'h0);
    tick();
    check_eq("b2b_drain", 32'(q_valid_out), 32'h0);

    // Output enable masks the word and blocks transfer while low.
    do_reset();
    q_ready_in = 1'b0;
    send_word(4'b1001);
    out_enable_in = 1'b0;
    q_ready_in    = 1'b1;
    #1;
    check_eq("oe_q_masked", 32'(q_out), 32'h0);
    check_eq("oe_valid_masked", 32'(q_valid_out), 32'h0);
    tick();
    check_eq("oe_still_masked", 32'(q_valid_out), 32'h0);
    out_enable_in = 1'b1;
    #1;
    check_eq("oe_q_back", 32'(q_out), 32'h9);
    check_eq("oe_valid_back", 32'(q_valid_out), 32'h1);
    tick();
    check_eq("oe_drain", 32'(q_valid_out), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
